// File: rtl/alul_pipe.sv
// alul_pipe -- two-stage pipelined logic/shift unit with valid/ready flow control.
//
// Ports:
//   CLK        sole clock, all state updates on the rising edge
//   RST        synchronous active-high reset
//   A, B       WIDTH-bit operands
//   SEL        3-bit operation select:
//                000 A&B   001 A|B   010 A^B    011 ~A
//                100 ~(A&B) 101 ~(A|B) 110 A<<1  111 A>>1
//   IN_VALID   operands/SEL valid
//   IN_READY   block can accept operands this cycle
//   OUT        registered result
//   CARRY      bit shifted out by the shift ops, 0 otherwise
//   ZERO       OUT == 0
//   PARITY     XOR-reduction of OUT
//   OUT_VALID  OUT and flags valid
//   OUT_READY  consumer accepts the result
//   ACC_SEL    (only with ALUL_ACC_EN) use the accumulator as an operand
//
// Optional feature: define ALUL_ACC_EN to add ACC_SEL and a WIDTH-bit
// accumulator that holds the result of the most recent accepted transaction.
// With ACC_SEL=1 the accumulator replaces B for the binary ops, and replaces
// A for ~A and the two shifts (the ops that only look at A).
//
// Handshake: a transfer happens on a rising edge where VALID and READY are both
// 1 on that interface. Once OUT_VALID is raised, OUT and the flags hold stable
// until the edge where OUT_READY is also 1. IN_READY never depends on IN_VALID.
//
// Pipeline: S1 captures the result at acceptance; S2 is the output register.
// Latency is 2 edges (accept at edge N, OUT_VALID after edge N+1), throughput
// one transaction per cycle.

module alul_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       SEL,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] OUT,
  output logic             CARRY,
  output logic             ZERO,
  output logic             PARITY,
  output logic             OUT_VALID,
  input  logic             OUT_READY
`ifdef ALUL_ACC_EN
  ,
  input  logic             ACC_SEL
`endif
);

  // Stage 1 registers
  logic             s1_valid;
  logic [WIDTH-1:0] s1_res;
  logic             s1_carry;
  logic             s1_zero;
  logic             s1_parity;

  logic             s2_ready;
  logic             in_fire;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] res;
  logic             carry;

`ifdef ALUL_ACC_EN
  logic [WIDTH-1:0] acc;
`endif

  // S2 can take new data when it is empty or its content leaves this edge.
  assign s2_ready = !OUT_VALID || OUT_READY;
  // S1 can take new data when it is empty or its content moves to S2 this edge.
  assign IN_READY = (!s1_valid || s2_ready) && !RST;
  assign in_fire  = IN_VALID && IN_READY;

  // Operand selection
  always_comb begin
    op_a = A;
    op_b = B;
`ifdef ALUL_ACC_EN
    if (ACC_SEL) begin
      // ~A and the shifts only use A, so the accumulator stands in for A there.
      if (SEL == 3'b011 || SEL[2:1] == 2'b11) begin
        op_a = acc;
      end else begin
        op_b = acc;
      end
    end
`endif
  end

  // Operation
  always_comb begin
    res   = '0;
    carry = 1'b0;
    case (SEL)
      3'b000: res = op_a & op_b;
      3'b001: res = op_a | op_b;
      3'b010: res = op_a ^ op_b;
      3'b011: res = ~op_a;
      3'b100: res = ~(op_a & op_b);
      3'b101: res = ~(op_a | op_b);
      3'b110: begin
        res   = {op_a[WIDTH-2:0], 1'b0};
        carry = op_a[WIDTH-1];
      end
      default: begin
        res   = {1'b0, op_a[WIDTH-1:1]};
        carry = op_a[0];
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid  <= 1'b0;
      s1_res    <= '0;
      s1_carry  <= 1'b0;
      s1_zero   <= 1'b0;
      s1_parity <= 1'b0;
      OUT_VALID <= 1'b0;
      OUT       <= '0;
      CARRY     <= 1'b0;
      ZERO      <= 1'b0;
      PARITY    <= 1'b0;
`ifdef ALUL_ACC_EN
      acc       <= '0;
`endif
    end else begin
      // S1 -> S2
      if (s2_ready) begin
        OUT_VALID <= s1_valid;
        if (s1_valid) begin
          OUT    <= s1_res;
          CARRY  <= s1_carry;
          ZERO   <= s1_zero;
          PARITY <= s1_parity;
        end
      end

      // Input -> S1; if nothing new arrives, S1 empties when it moved on.
      if (in_fire) begin
        s1_valid  <= 1'b1;
        s1_res    <= res;
        s1_carry  <= carry;
        s1_zero   <= (res == '0);
        s1_parity <= ^res;
      end else if (s2_ready) begin
        s1_valid <= 1'b0;
      end

`ifdef ALUL_ACC_EN
      if (in_fire) begin
        acc <= res;
      end
`endif
    end
  end

endmodule

// File: doc/alul_pipe.md
ALUL_PIPE -- requirements
Module: alul_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits; legal range 2..64.
REQ-002 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port A  input  WIDTH  operand A.
REQ-005 SHALL have port B  input  WIDTH  operand B.
REQ-006 SHALL have port SEL  input  3  operation select.
REQ-007 SHALL have port IN_VALID  input  1  operands/SEL valid.
REQ-008 SHALL have port IN_READY  output  1  block can accept operands this cycle.
REQ-009 SHALL have port OUT  output  WIDTH  registered result.
REQ-010 SHALL have port CARRY  output  1  bit shifted out; 0 for non-shift ops.
REQ-011 SHALL have port ZERO  output  1  OUT == 0.
REQ-012 SHALL have port PARITY  output  1  XOR-reduction of OUT.
REQ-013 SHALL have port OUT_VALID  output  1  OUT/flags valid.
REQ-014 SHALL have port OUT_READY  input  1  consumer accepts result.

Function
REQ-015 SEL encoding SHALL be: 000 A&B, 001 A|B, 010 A^B, 011 ~A, 100 ~(A&B), 101 ~(A|B), 110 A<<1 (LSB 0, CARRY=A[WIDTH-1]), 111 A>>1 (MSB 0, CARRY=A[0]).
REQ-016 Transfer SHALL occur on an edge where VALID and READY are both 1 at that interface.
REQ-017 Result, CARRY, ZERO, PARITY SHALL be computed from the values at acceptance and stored in stage 1 (S1).
REQ-018 S1 contents SHALL move to output stage S2 when S2 empty or S2 transferring in the same edge.
REQ-019 Latency SHALL be 2 cycles: acceptance at edge N -> OUT_VALID=1 after edge N+1 with no stall; throughput 1 per cycle.
REQ-020 IN_READY SHALL be (!S1_valid || S2_ready) && !RST, where S2_ready = !OUT_VALID || OUT_READY.
REQ-021 While OUT_VALID=1 and OUT_READY=0, OUT, CARRY, ZERO, PARITY SHALL hold stable.
REQ-022 With both stages full and OUT_READY=0, IN_READY SHALL be 0; no transaction SHALL be dropped or duplicated.
REQ-023 Simultaneous acceptance at input and output in one edge SHALL keep occupancy constant and preserve order.
REQ-024 Unused SEL values SHALL not exist; all 8 codes are defined.

Reset
REQ-025 RST=1 at an edge SHALL clear S1/S2 valid, OUT=0, CARRY=0, ZERO=0, PARITY=0, OUT_VALID=0, accumulator=0.
REQ-026 RST asserted mid-operation SHALL discard all in-flight results; IN_VALID during RST SHALL not be accepted.
REQ-027 First acceptance SHALL be possible at the first edge with RST=0.

Configuration
REQ-028 Macro ALUL_ACC_EN SHALL, when defined, add input ACC_SEL (1 bit) and a WIDTH-bit accumulator holding the result of the most recent accepted transaction.
REQ-029 With ALUL_ACC_EN and ACC_SEL=1 at acceptance, the accumulator value SHALL replace B; for ~A and shifts, it SHALL replace A.
REQ-030 Without ALUL_ACC_EN, no ACC_SEL port or accumulator SHALL exist; B always used.

Verification
REQ-031 WIDTH=8, A=0x0F, B=0x05, SEL 000..111 back-to-back, OUT_READY=1 -> OUT 0x05,0x0F,0x0A,0xF0,0xFA,0xF0,0x1E,0x07, each 2 cycles after acceptance, one per cycle.
REQ-032 A=0x0F, B=0xF0, SEL=000 -> OUT=0x00, ZERO=1, PARITY=0; A=0x80, SEL=110 -> OUT=0x00, CARRY=1, ZERO=1.
REQ-033 OUT_READY=0, 3 transactions offered -> 2 accepted, IN_READY=0, OUT holds first result; OUT_READY=1 -> all 3 delivered in order.
REQ-034 RST pulsed with both stages full -> next cycle OUT_VALID=0, OUT=0, IN_READY=1; no stale result emitted.
REQ-035 ALUL_ACC_EN: A=0x0F, B=0x05, SEL=000 then A=0x03, ACC_SEL=1, SEL=001 -> OUT 0x05 then 0x07.
REQ-036 Random OUT_READY toggling over 1000 transactions -> output sequence matches reference model exactly.
